dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised, byte-addressable, big-endian data memory for the MIPS datapath. It replaces the fixed 32-byte data memory with configurable depth and byte/half/word accesses with sign or zero extension. It adds a valid/ready request handshake, configurable wait states, alignment and range error reporting, and a self-clearing sequence after reset. The load/store unit drives the request side and consumes the one-cycle response pulse.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, minimum 16.
ADDR_W, 32, request address width.
WAIT_STATES, 1, extra cycles between request acceptance and response; range 0..7.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load data, extended; 0 for stores and errors
rsp_err  output  1  qualified by rsp_valid; misaligned, out of range, or illegal size
busy_clear  output  1  high while the post-reset clear sequence runs

Behaviour:
- Reset (rst_n low, asynchronous): state goes to CLEAR and the clear index goes to 0. Outputs during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy_clear=1. Asserting reset mid-access aborts the access with no response; a partially performed store is discarded by the clear sequence.
- Storage: 4 byte lanes of DEPTH_BYTES/4 entries each. Lane 0 holds address offset 0, which is bits [31:24] of a word (big-endian). Word index is addr[log2(DEPTH_BYTES)-1:2].
- CLEAR: one word written to zero per cycle across all lanes, taking DEPTH_BYTES/4 cycles; then go to IDLE. Requests are ignored during CLEAR.
- IDLE: req_ready=1. On req_valid && req_ready, latch we/size/unsigned/addr/wdata. Go to WAIT if WAIT_STATES>0, else go to ACCESS.
- WAIT: down-counter loaded with WAIT_STATES-1 at acceptance. Go to ACCESS when it reaches 0. Request inputs are ignored in WAIT.
- ACCESS (one cycle): error check, then store commit or load read. Next state is IDLE. rsp_valid, rsp_rdata and rsp_err are registered and visible in the cycle after ACCESS.
- Latency: rsp_valid is high in cycle N+WAIT_STATES+2 when acceptance happens at edge N. req_ready returns high together with rsp_valid, so back-to-back requests are allowed. Responses have no backpressure.
- Error conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr >= DEPTH_BYTES;
  - req_size=11.
  On error: no lane is written, rsp_rdata=0, rsp_err=1.
- Store lane enables by size:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: addr[1]=0 writes lanes 0,1 with wdata[15:8],[7:0]; addr[1]=1 writes lanes 2,3 with the same bytes.
  - word: all lanes, lane 0 = wdata[31:24].
- Loads: the selected byte or half is right-aligned, then sign- or zero-extended to 32 bits. Stores return rsp_rdata=0, rsp_err=0.

Decomposition:
- Package dmem_pkg holds:
  - the size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - the state enum {CLEAR, IDLE, WAIT, ACCESS};
  - a lane-enable function (size, addr[1:0]) returning 4 bits.
- One sub-module, dmem_lane: a single-port byte RAM with a synchronous write enable and registered read, depth DEPTH_BYTES/4, instantiated four times.

Test Plan:
1. Clear sequence: release reset with DEPTH_BYTES=64 -> busy_clear high for exactly 16 cycles, then req_ready=1. A word load from 0x20 returns 0x00000000, rsp_err=0.
2. Word store/load: store 0xDEADBEEF at 0x10, then byte loads at 0x10..0x13 -> 0xFFFFFFDE, 0xFFFFFFAD, 0xFFFFFFBE, 0xFFFFFFEF. Unsigned byte load at 0x11 -> 0x000000AD.
3. Half store: store half 0x8001 at 0x22 -> word load at 0x20 returns 0x00008001. Signed half load at 0x22 -> 0xFFFF8001.
4. Errors: word load at 0x13, half store at 0x05, word load at 0x40 (DEPTH=64), size=11 -> each gives rsp_err=1, rsp_rdata=0. A follow-up load confirms memory is unchanged.
5. Latency: WAIT_STATES=0 and WAIT_STATES=3 with back-to-back requests -> rsp_valid at acceptance+2 and +5. req_ready low between acceptance and response.
6. Reset mid-access: assert rst_n low during WAIT of a store -> no rsp_valid. Clear runs again; a later load of that address returns 0.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared encodings and helpers for the byte-addressable,
//            big-endian data memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } state_e;

  // Byte-lane enables for a store. Bit i enables lane i, and lane 0 is
  // address offset 0 (the most significant byte of the big-endian word).
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] en;
    en = 4'b0000;
    case (size)
      SZ_BYTE: en = 4'b0001 << off;
      SZ_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane
// Purpose  : Single-port byte RAM, one lane of the data memory.
//            Synchronous write, registered read (read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Write port and registered read port share the same address
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule : dmem_lane
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Parametrised big-endian data memory with valid/ready request
//            handshake, wait states, byte/half/word accesses, error
//            reporting and a self-clearing sequence after reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy_clear
);

  localparam int                 c_AW       = $clog2(DEPTH_BYTES);
  localparam int                 c_IDX_W    = c_AW - 2;
  localparam int                 c_WORDS    = DEPTH_BYTES / 4;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_WORDS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = 1;
  localparam logic [2:0]         c_WAIT_LD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [ADDR_W-1:0]  c_LIMIT    = ADDR_W'(DEPTH_BYTES);

  // State and request registers
  state_e              state_q, state_d;
  logic [c_IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // RAM interface and datapath wires
  logic [c_IDX_W-1:0]  w_ram_idx;
  logic [3:0]          w_ram_we;
  logic [7:0]          w_lane_wd [4];
  logic [7:0]          w_lane_rd [4];
  logic                w_err;
  logic [31:0]         w_ld;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;

  // Latched request is checked against alignment, range and size rules
  assign w_err = ((size_q == SZ_HALF) && addr_q[0])
               | ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
               | (addr_q >= c_LIMIT)
               | (size_q == SZ_ILL);

  // The RAM is read on the edge that enters the next state, so in IDLE the
  // incoming address is presented; that makes the data ready in ACCESS even
  // with zero wait states.
  assign w_ram_idx = (state_q == CLEAR) ? clr_idx_q :
                     (state_q == IDLE)  ? req_addr[c_AW-1:2] :
                                          addr_q[c_AW-1:2];

  assign w_ram_we = (state_q == CLEAR) ? 4'b1111 :
                    ((state_q == ACCESS) && we_q && !w_err) ? lane_en(size_q, addr_q[1:0]) :
                                                              4'b0000;

  // Four byte lanes; store data is steered per lane from the right-aligned
  // request data, and cleared to zero during the clear sequence.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_lane_wd[i] = (state_q == CLEAR)   ? 8'h00 :
                          (size_q == SZ_WORD)  ? wdata_q[31-8*i -: 8] :
                          ((size_q == SZ_HALF) && ((i % 2) == 0)) ? wdata_q[15:8] :
                                                                    wdata_q[7:0];

    dmem_lane #(
      .DEPTH (c_WORDS)
    ) u_lane (
      .clk     (clk),
      .we_i    (w_ram_we[i]),
      .addr_i  (w_ram_idx),
      .wdata_i (w_lane_wd[i]),
      .rdata_o (w_lane_rd[i])
    );
  end

  assign w_byte = w_lane_rd[addr_q[1:0]];
  assign w_half = addr_q[1] ? {w_lane_rd[2], w_lane_rd[3]} : {w_lane_rd[0], w_lane_rd[1]};

  // Right-align the selected byte/half and extend it to 32 bits
  always_comb begin
    w_ld = 32'h0;
    case (size_q)
      SZ_BYTE: w_ld = uns_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_ld = uns_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      SZ_WORD: w_ld = {w_lane_rd[0], w_lane_rd[1], w_lane_rd[2], w_lane_rd[3]};
      default: w_ld = 32'h0;
    endcase
  end

  // Next-state, request capture and response generation
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + c_IDX_ONE;
        if (clr_idx_q == c_LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          uns_d      = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          wait_cnt_d = c_WAIT_LD;
          state_d    = (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = w_err;
        rsp_rdata_d = (w_err || we_q) ? 32'h0 : w_ld;
        state_d     = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // State register; reset restarts the clear sequence and drops any access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      wait_cnt_q  <= 3'd0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy_clear = (state_q == CLEAR);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule : dmem_ctrl
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Self-checking bench for dmem_ctrl (directed vector table plus
//            hand-written clear, latency and reset-abort sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;
  localparam int         WS_MAIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err, busy_clear;

  logic        b_valid, b_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [31:0] b_rdata;

  dmem_ctrl #(.DEPTH_BYTES(64), .ADDR_W(32), .WAIT_STATES(WS_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy_clear(busy_clear)
  );

  dmem_ctrl #(.DEPTH_BYTES(64), .ADDR_W(32), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(1'b0), .req_size(W), .req_unsigned(1'b0),
    .req_addr(32'h0), .req_wdata(32'h0), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rdata), .rsp_err(b_rsp_err), .busy_clear(b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic add(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    vecs[nv].we = we; vecs[nv].sz = sz; vecs[nv].uns = uns; vecs[nv].addr = addr;
    vecs[nv].wd = wd; vecs[nv].exp_rd = exp_rd; vecs[nv].exp_err = exp_err;
    nv++;
  endtask

  // Issue one request when ready, return response and latency (negedges
  // after the accepting edge until rsp_valid is seen).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int  guard;
    logic early;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    early = 1'b0;
    while (!rsp_valid && lat < 50) begin
      if (req_ready) early = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("ready_low_in_flight", {31'h0, early}, 32'h0);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, cnt;
    logic        seen;

    req_valid = 0; req_we = 0; req_size = W; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; b_valid = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_busy_clear", {31'h0, busy_clear}, 32'h1);

    // Clear sequence length: 64 bytes -> 16 words
    rst_n = 1'b1;
    cnt = 0;
    while (busy_clear && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_cycles", cnt, 32'd16);
    chk("ready_after_clear", {31'h0, req_ready}, 32'h1);
    chk("b_busy_done", {31'h0, b_busy}, 32'h0);

    // Zero wait states, back-to-back with valid held high
    chk("b_ready_start", {31'h0, b_ready}, 32'h1);
    b_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b_ready_access", {31'h0, b_ready}, 32'h0);
      chk("b_rsp_not_yet", {31'h0, b_rsp_valid}, 32'h0);
      @(negedge clk);
      chk("b_rsp_valid", {31'h0, b_rsp_valid}, 32'h1);
      chk("b_ready_with_rsp", {31'h0, b_ready}, 32'h1);
      chk("b_rdata", b_rdata, 32'h0);
      chk("b_err", {31'h0, b_rsp_err}, 32'h0);
    end
    b_valid = 1'b0;

    // Directed vector table (DEPTH_BYTES=64)
    add(0, W, 0, 32'h20, 32'h0,        32'h00000000, 0);
    add(1, W, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 0);
    add(0, B, 0, 32'h10, 32'h0,        32'hFFFFFFDE, 0);
    add(0, B, 0, 32'h11, 32'h0,        32'hFFFFFFAD, 0);
    add(0, B, 0, 32'h12, 32'h0,        32'hFFFFFFBE, 0);
    add(0, B, 0, 32'h13, 32'h0,        32'hFFFFFFEF, 0);
    add(0, B, 1, 32'h11, 32'h0,        32'h000000AD, 0);
    add(1, H, 0, 32'h22, 32'h00008001, 32'h00000000, 0);
    add(0, W, 0, 32'h20, 32'h0,        32'h00008001, 0);
    add(0, H, 0, 32'h22, 32'h0,        32'hFFFF8001, 0);
    add(0, H, 1, 32'h22, 32'h0,        32'h00008001, 0);
    add(0, H, 0, 32'h10, 32'h0,        32'hFFFFDEAD, 0);
    add(0, W, 0, 32'h13, 32'h0,        32'h00000000, 1);
    add(1, H, 0, 32'h05, 32'h00001234, 32'h00000000, 1);
    add(0, W, 0, 32'h40, 32'h0,        32'h00000000, 1);
    add(0, X, 0, 32'h10, 32'h0,        32'h00000000, 1);
    add(1, X, 0, 32'h10, 32'h12345678, 32'h00000000, 1);
    add(1, W, 0, 32'h44, 32'hCAFEF00D, 32'h00000000, 1);
    add(0, W, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);
    add(0, W, 0, 32'h04, 32'h0,        32'h00000000, 0);
    add(1, B, 0, 32'h21, 32'h0000007F, 32'h00000000, 0);
    add(0, W, 0, 32'h20, 32'h0,        32'h007F8001, 0);
    add(1, W, 0, 32'h3C, 32'h01020304, 32'h00000000, 0);
    add(0, H, 1, 32'h3E, 32'h0,        32'h00000304, 0);
    add(0, B, 0, 32'h3C, 32'h0,        32'h00000001, 0);
    add(1, B, 0, 32'h2F, 32'hFFFFFF80, 32'h00000000, 0);
    add(0, B, 1, 32'h2F, 32'h0,        32'h00000080, 0);
    add(0, W, 0, 32'h2C, 32'h0,        32'h00000080, 0);

    for (int i = 0; i < nv; i++) begin
      do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_latency", i), lat, WS_MAIN + 2);
    end

    // Reset during the wait phase of a store aborts it; memory is cleared
    do_req(1, W, 0, 32'h30, 32'h11223344, rd, er, lat);
    do_req(0, W, 0, 32'h30, 32'h0, rd, er, lat);
    chk("pre_reset_word", rd, 32'h11223344);
    req_we = 1; req_size = W; req_unsigned = 0; req_addr = 32'h30; req_wdata = 32'hAAAAAAAA;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("in_wait_ready_low", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("reset_busy_clear", {31'h0, busy_clear}, 32'h1);
    rst_n = 1'b1;
    cnt = 0;
    while (busy_clear && cnt < 100) begin
      if (rsp_valid) seen = 1'b1;
      cnt++;
      @(negedge clk);
    end
    chk("no_rsp_after_abort", {31'h0, seen}, 32'h0);
    chk("reclear_cycles", cnt, 32'd16);
    do_req(0, W, 0, 32'h30, 32'h0, rd, er, lat);
    chk("post_reset_word", rd, 32'h0);
    chk("post_reset_err", {31'h0, er}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule : tb_dmem_ctrl
`default_nettype wire
